// File: rtl/prng_sched_pkg.sv
// prng_sched_pkg: shared state encoding, seed width and sizing helpers for prng_sched.
package prng_sched_pkg;
  localparam int SEED_W = 80;
  typedef enum logic [1:0] {FETCH = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, RUN = 2'd3} state_e;
  function automatic int cnt_w(int p);
    return (p < 1) ? 1 : $clog2(p + 1);
  endfunction
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/prng_sched_if.sv
// prng_sched_if: seed source, prng_top and consumer signals of the reseed scheduler.
interface prng_sched_if #(parameter int RND = 128, parameter int NREQ = 2);
  import prng_sched_pkg::*;
  logic              seed_in_valid;
  logic              seed_in_ready;
  logic [SEED_W-1:0] seed_in_data;
  logic              force_reseed;
  logic              prng_start_reseed;
  logic [SEED_W-1:0] prng_seed;
  logic              prng_busy;
  logic              prng_out_valid;
  logic              prng_out_ready;
  logic [RND-1:0]    prng_out_rnd;
  logic [NREQ-1:0]   cons_ready;
  logic [NREQ-1:0]   cons_valid;
  logic [RND-1:0]    cons_rnd;
  logic              seeded;
  modport master (
    input  seed_in_valid, seed_in_data, force_reseed, prng_busy, prng_out_valid, prng_out_rnd, cons_ready,
    output seed_in_ready, prng_start_reseed, prng_seed, prng_out_ready, cons_valid, cons_rnd, seeded
  );
  modport slave (
    output seed_in_valid, seed_in_data, force_reseed, prng_busy, prng_out_valid, prng_out_rnd, cons_ready,
    input  seed_in_ready, prng_start_reseed, prng_seed, prng_out_ready, cons_valid, cons_rnd, seeded
  );
endinterface

// File: rtl/prng_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr.
module rr_arbiter
  import prng_sched_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int PW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx
);
  // Scan from farthest to nearest so the requester closest to ptr wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NREQ]) begin
        gnt = NREQ'(1) << ((int'(ptr) + k) % NREQ);
        idx = PW'((int'(ptr) + k) % NREQ);
      end
  end
endmodule

// File: rtl/prng_sched.sv
// prng_sched: fetches seeds, drives prng_top reseeds, enforces the per-seed word budget
// and shares the random stream round-robin among NREQ consumers.
module prng_sched
  import prng_sched_pkg::*;
#(
  parameter int RND           = 128,
  parameter int NREQ          = 2,
  parameter int RESEED_PERIOD = 1024
) (
  input logic         clk,
  input logic         rst,
  prng_sched_if.master bus
);
  localparam int CW = cnt_w(RESEED_PERIOD);
  localparam int PW = idx_w(NREQ);
  state_e            state_q, state_d;
  logic [SEED_W-1:0] seed_q, seed_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic              seeded_q, seeded_d;
  logic [NREQ-1:0]   req, gnt;
  logic [PW-1:0]     gidx;
  logic              xfer;
  logic              unused_busy;
  assign req = (state_q == RUN && bus.prng_out_valid) ? bus.cons_ready : '0;
  rr_arbiter #(.NREQ(NREQ)) u_arb (.req(req), .ptr(ptr_q), .gnt(gnt), .idx(gidx));
  assign xfer                  = |gnt;
  assign unused_busy           = bus.prng_busy;
  assign bus.cons_valid        = gnt;
  assign bus.prng_out_ready    = xfer;
  assign bus.cons_rnd          = RND'(bus.prng_out_rnd);
  assign bus.seed_in_ready     = state_q == FETCH;
  assign bus.prng_start_reseed = state_q == LAUNCH;
  assign bus.prng_seed         = seed_q;
  assign bus.seeded            = seeded_q;
  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    seeded_d = seeded_q;
    case (state_q)
      FETCH: if (bus.seed_in_valid) begin
        seed_d  = bus.seed_in_data;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: if (bus.prng_out_valid) begin
        seeded_d = 1'b1;
        state_d  = RUN;
      end
      default: begin
        cnt_d = cnt_q + CW'(xfer);
        ptr_d = xfer ? ((gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1)) : ptr_q;
        if ((xfer && cnt_d == CW'(RESEED_PERIOD)) || bus.force_reseed) state_d = FETCH;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH;
      seed_q   <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      seeded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      seeded_q <= seeded_d;
    end
  end
endmodule

// File: doc/prng_sched.md
# prng_sched

Reseed scheduler and output arbiter for one `prng_top` instance. It fetches 80-bit seeds from an upstream seed source and drives the PRNG reseed procedure. It enforces a hard budget of `RESEED_PERIOD` output words per seed, then reseeds automatically. It shares the single SVRS randomness stream round-robin among `NREQ` consumers, such as masked AES gadgets.

## Interface
Parameters:
- `RND`, 128, width of one random word; must equal the `prng_top` `RND`.
- `NREQ`, 2, number of consumers (≥1).
- `RESEED_PERIOD`, 1024, words delivered per seed (≥1).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `seed_in_valid`  in  1  fresh seed offered by the seed source.
- `seed_in_ready`  out  1  scheduler accepts the seed.
- `seed_in_data`  in  80  seed value.
- `force_reseed`  in  1  request an immediate reseed; honoured in RUN only.
- `prng_start_reseed`  out  1  single-cycle pulse to `prng_top.start_reseed`.
- `prng_seed`  out  80  registered seed, to `prng_top.seed`.
- `prng_busy`  in  1  from `prng_top.busy`; observed for status only.
- `prng_out_valid`  in  1  from `prng_top.out_valid`.
- `prng_out_ready`  out  1  to `prng_top.out_ready`.
- `prng_out_rnd`  in  RND  from `prng_top.out_rnd`.
- `cons_ready`  in  NREQ  consumer i wants a word.
- `cons_valid`  out  NREQ  one-hot; word presented to consumer i.
- `cons_rnd`  out  RND  shared data bus; equals `prng_out_rnd`.
- `seeded`  out  1  high once the first seed has produced valid output; cleared only by reset.

## Operation
- FSM states: FETCH, LAUNCH, WAIT, RUN. `rst` forces FETCH.
- FETCH:
  - `seed_in_ready`=1.
  - On `seed_in_valid`, capture `seed_in_data` into `prng_seed` and go to LAUNCH.
- LAUNCH:
  - `prng_start_reseed`=1 for exactly one cycle.
  - Transfer counter clears to 0.
  - Next state is WAIT.
- WAIT:
  - No deliveries.
  - Go to RUN when `prng_out_valid`=1.
  - `prng_out_valid` is low from the cycle after LAUNCH until `prng_top` finishes reseeding.
- RUN:
  - Arbiter picks the first requester with `cons_ready` set, searching from the round-robin pointer with wrap-around.
  - `cons_valid[g]`=1 only for the picked requester, only in RUN, and only when `prng_out_valid`=1.
  - Transfer = `cons_valid[g]` & `cons_ready[g]`.
  - `prng_out_ready` equals transfer.
  - On a transfer: counter += 1 and pointer ← (g+1) mod NREQ.
  - If no requester is ready, the pointer is held.
- Leaving RUN for FETCH happens on either of:
  - a transfer that makes the counter equal `RESEED_PERIOD` (the last word is delivered);
  - `force_reseed`=1. A transfer in that same cycle still completes and is counted.
- Budget:
  - Never more than `RESEED_PERIOD` transfers between two LAUNCH pulses.
  - Counter width is max(1, $clog2(RESEED_PERIOD+1)); no wrap is possible.
- `force_reseed` is ignored in FETCH, LAUNCH and WAIT; the reseed already in progress covers it. It is not latched.
- `seeded` is set on the first WAIT→RUN transition.
- `cons_rnd` is a direct wire from `prng_out_rnd`; no data register.

## Timing
- Reset values:
  - state=FETCH, so `seed_in_ready`=1.
  - `prng_start_reseed`=0, `prng_out_ready`=0, `cons_valid`=0.
  - `seeded`=0, `prng_seed`=0, counter=0, pointer=0.
- Seed accepted at cycle t: `prng_start_reseed` pulses at t+1 with the new `prng_seed` already stable; WAIT begins at t+2.
- `prng_seed` holds its value until the next seed capture.
- Combinational paths: `cons_ready` → `cons_valid` → `prng_out_ready`. `prng_out_rnd` is registered inside `prng_top`, so the data path is glitch-free.
- Throughput in RUN: one word per cycle when any requester is ready.
- Reset mid-operation: outputs take their reset values immediately, without a clock edge. The system ties this `rst` to `prng_top.rst`, so after reset the PRNG is in INIT and the first LAUNCH is valid.

## Structure
- Package `prng_sched_pkg`:
  - state encoding localparams (FETCH=0, LAUNCH=1, WAIT=2, RUN=3);
  - `SEED_W`=80.
- Sub-module `rr_arbiter #(NREQ)`:
  - inputs: req vector, pointer;
  - outputs: one-hot grant, grant index.
  - Purely combinational; the pointer register lives in `prng_sched`.

## Test plan
- Reset, seed 80'h0123_4567_89AB_CDEF_0011 valid at cycle 3 → `seed_in_ready` drops at cycle 4, one-cycle `prng_start_reseed` at cycle 4 with `prng_seed`=that value, `seeded` rises when `prng_top.out_valid` rises.
- NREQ=2, both `cons_ready` held high → grants alternate 0,1,0,1; `prng_out_ready`=1 every RUN cycle; each consumer receives distinct consecutive words.
- RESEED_PERIOD=4, one requester always ready → exactly 4 transfers, then `cons_valid`=0 and `seed_in_ready`=1; no 5th transfer before new seed and `prng_out_valid`.
- `force_reseed` in RUN concurrent with a transfer → transfer counted, FETCH next cycle. `force_reseed` held through WAIT → exactly one `prng_start_reseed` pulse.
- Pointer=0, only `cons_ready[1]`=1 → `cons_valid`=2'b10 the same cycle; after the transfer, pointer=0 (wrap).
- `rst` asserted asynchronously mid-WAIT → `cons_valid`=0, `seeded`=0, `seed_in_ready`=1 before the next clock edge; the full reseed sequence restarts after release.
